bf16_spi_cmd_master: RTL and testbench

- SPI master that issues bfloat16 processor commands (opcode word plus 0–2 operand words) to the processor's SPI slave port.
- Each 16-bit word is framed with its own cs low pulse and shifted LSB first.
- The response word is captured from miso during the last word of each command.
- Sits between a host-side command interface (valid/ready) and the processor pins sck/mosi/cs/miso.

---
 rtl/bf16_spi_cmd_master.sv | 218 +++++++++++++++++++++
 tb/tb_bf16_spi_cmd_master.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_spi_cmd_master.sv
// bf16_spi_cmd_master
// SPI master that sends a bfloat16 processor command (opcode word plus
// zero, one or two operand words) to the processor's SPI slave port. Every
// 16-bit word gets its own cs-low window and is shifted LSB first. The word
// returned on miso during the final word of a command is kept in rx_word.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready host handshake; command taken when both are high
//   cmd_opcode          opcode word (legal 0x0000-0x000A)
//   cmd_op_a, cmd_op_b  bfloat16 operands
//   sck, mosi, cs, miso SPI pins (sck idles low, cs active low)
//   busy                high from acceptance until the command finishes
//   done                one-cycle pulse when the command completes
//   err                 one-cycle pulse when an illegal opcode is offered
//   rx_word             miso word captured during the last word of a command
//   word_idx            index of the word being shifted (0 = opcode)
//
// Parameters:
//   SCK_DIV     clk cycles per sck half-period (>= 1)
//   GAP_HALVES  sck half-periods cs stays high after each word; a value of 0
//               still leaves cs high for one clk cycle so words never merge

module bf16_spi_cmd_master #(
    parameter int SCK_DIV    = 2,
    parameter int GAP_HALVES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_opcode,
    input  logic [15:0] cmd_op_a,
    input  logic [15:0] cmd_op_b,
    output logic        sck,
    output logic        mosi,
    output logic        cs,
    input  logic        miso,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rx_word,
    output logic [1:0]  word_idx
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        GAP,
        DONE
    } state_t;

    localparam int GAP_CYCLES = GAP_HALVES * SCK_DIV;
    localparam int CNT_MAX    = (GAP_CYCLES > SCK_DIV) ? GAP_CYCLES : SCK_DIV;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [15:0]      tx_shift;
    logic [15:0]      rx_shift;
    logic [15:0]      op_a_q;
    logic [15:0]      op_b_q;
    logic [1:0]       last_idx;

    logic             op_legal;
    logic [1:0]       op_count;
    logic [15:0]      next_word;

    // Decode how many operand words follow the opcode; anything outside the
    // table is rejected at the handshake without touching the SPI pins.
    always_comb begin
        op_legal = 1'b1;
        op_count = 2'd0;
        case (cmd_opcode)
            16'h0000, 16'h0002:                       op_count = 2'd0;
            16'h0001, 16'h0007, 16'h0008:             op_count = 2'd1;
            16'h0003, 16'h0004, 16'h0005, 16'h0006,
            16'h0009, 16'h000A:                       op_count = 2'd2;
            default:                                  op_legal = 1'b0;
        endcase
    end

    // Word that follows the current one: index 1 is op_a, index 2 is op_b.
    always_comb begin
        next_word = (word_idx == 2'd0) ? op_a_q : op_b_q;
    end

    // Single sequencer. Every pin and status output is a register updated on
    // the same edge as the state change, so the outputs seen during a state
    // are the ones that state is defined to drive. The shifter and cs are
    // loaded on the edge entering LOAD so bit 0 is on mosi for the whole
    // LOAD cycle and the first SHIFT_LO half-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            last_idx  <= '0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            cs        <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rx_word   <= '0;
            word_idx  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (op_legal) begin
                            op_a_q    <= cmd_op_a;
                            op_b_q    <= cmd_op_b;
                            last_idx  <= op_count;
                            word_idx  <= 2'd0;
                            tx_shift  <= cmd_opcode;
                            mosi      <= cmd_opcode[0];
                            rx_shift  <= '0;
                            cs        <= 1'b0;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    state   <= SHIFT_LO;
                end

                SHIFT_LO: begin
                    if (cnt == HALF_LAST) begin
                        // miso has been stable since the previous falling
                        // edge, so it is captured on the edge that raises sck.
                        cnt      <= '0;
                        sck      <= 1'b1;
                        rx_shift <= {miso, rx_shift[15:1]};
                        state    <= SHIFT_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SHIFT_HI: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        sck <= 1'b0;
                        if (bit_cnt == 4'd15) begin
                            cs    <= 1'b1;
                            mosi  <= 1'b0;
                            state <= GAP;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            tx_shift <= {1'b0, tx_shift[15:1]};
                            mosi     <= tx_shift[1];
                            state    <= SHIFT_LO;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (word_idx != last_idx) begin
                            word_idx <= word_idx + 1'b1;
                            tx_shift <= next_word;
                            mosi     <= next_word[0];
                            rx_shift <= '0;
                            cs       <= 1'b0;
                            state    <= LOAD;
                        end else begin
                            rx_word <= rx_shift;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    cs        <= 1'b1;
                    sck       <= 1'b0;
                    mosi      <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_spi_cmd_master.sv
// tb_bf16_spi_cmd_master
// Directed bench for bf16_spi_cmd_master at default parameters. A pin
// monitor watches cs/sck/mosi on the falling clk edge, reassembles each
// cs-low window LSB first, counts sck rises, measures cs-high gaps, and
// plays back a slave response word per window on miso.

module tb_bf16_spi_cmd_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_opcode;
    logic [15:0] cmd_op_a;
    logic [15:0] cmd_op_b;
    logic        sck;
    logic        mosi;
    logic        cs;
    logic        miso;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rx_word;
    logic [1:0]  word_idx;

    int compareCount;
    int mismatchCount;

    bf16_spi_cmd_master #(
        .SCK_DIV   (2),
        .GAP_HALVES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_op_a  (cmd_op_a),
        .cmd_op_b  (cmd_op_b),
        .sck       (sck),
        .mosi      (mosi),
        .cs        (cs),
        .miso      (miso),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rx_word   (rx_word),
        .word_idx  (word_idx)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin monitor and slave model state
    logic [15:0] slaveWords [4];
    logic [15:0] seenWords  [8];
    int          seenRises  [8];
    int          seenIdx    [8];
    int          seenGap    [8];
    int          monWin;
    int          monCur;
    int          monRise;
    int          straySck;
    int          gapCnt;
    logic [15:0] monCap;
    logic        prevCs;
    logic        prevSck;
    logic        monClear;

    // Observe pins half a clock after the DUT updates them; a falling cs
    // opens a window, each sck rise inside it captures one mosi bit, and a
    // rising cs closes the window.
    always @(negedge clk) begin
        if (monClear) begin
            monWin   = 0;
            monCur   = 0;
            monRise  = 0;
            straySck = 0;
            gapCnt   = 0;
            monCap   = '0;
            for (int i = 0; i < 8; i++) begin
                seenWords[i] = '0;
                seenRises[i] = 0;
                seenIdx[i]   = 0;
                seenGap[i]   = 0;
            end
        end else begin
            if (prevCs && !cs) begin
                monCur  = monWin;
                monWin  = monWin + 1;
                monRise = 0;
                monCap  = '0;
                if (monCur < 8) begin
                    seenIdx[monCur] = int'(word_idx);
                    seenGap[monCur] = gapCnt;
                end
            end
            if (sck && !prevSck) begin
                if (cs) begin
                    straySck = straySck + 1;
                end else begin
                    if (monRise < 16) monCap[monRise] = mosi;
                    monRise = monRise + 1;
                end
            end
            if (!prevCs && cs) begin
                if (monCur < 8) begin
                    seenWords[monCur] = monCap;
                    seenRises[monCur] = monRise;
                end
                gapCnt = 0;
            end
            if (cs) gapCnt = gapCnt + 1;
        end
        prevCs  = cs;
        prevSck = sck;
    end

    // Slave drives the next response bit as soon as the previous rise is seen
    always_comb begin
        miso = 1'b0;
        if (monRise < 16) miso = slaveWords[monCur[1:0]][monRise];
    end

    // Count one comparison and report it if the observed value differs
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount = compareCount + 1;
        if (observed !== expected) begin
            mismatchCount = mismatchCount + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Step to just after the next falling clk edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clearMonitor();
        tick();
        monClear = 1'b1;
        tick();
        monClear = 1'b0;
    endtask

    // Present one command and wait for done. lat counts cycles from the
    // handshake cycle (cycle 0) to the cycle in which done is high.
    // With scramble set, cmd_valid stays high and the inputs keep changing.
    task automatic applyStimulus(input logic [15:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input bit scramble,
                                 output int lat, output int readyHigh);
        bit got;
        tick();
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_op_a   = a;
        cmd_op_b   = b;
        lat        = 0;
        readyHigh  = 0;
        got        = 1'b0;
        while (!got && lat < 2000) begin
            tick();
            lat = lat + 1;
            if (scramble) begin
                cmd_opcode = 16'h0002;
                cmd_op_a   = 16'(lat * 16'h0101);
                cmd_op_b   = ~16'(lat * 16'h0303);
            end else if (lat == 1) begin
                cmd_valid = 1'b0;
            end
            if (done) got = 1'b1;
            else if (cmd_ready) readyHigh = readyHigh + 1;
        end
        if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    int  lat;
    int  readyHigh;
    bit  found;

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_op_a   = '0;
        cmd_op_b   = '0;
        monClear   = 1'b1;
        prevCs     = 1'b1;
        prevSck    = 1'b0;
        slaveWords[0] = 16'h1234;
        slaveWords[1] = 16'h0000;
        slaveWords[2] = 16'hBEEF;
        slaveWords[3] = 16'h0000;

        // Reset state
        repeat (3) tick();
        checkOutput("rst_cs", 32'(cs), 32'd1);
        checkOutput("rst_sck", 32'(sck), 32'd0);
        checkOutput("rst_mosi", 32'(mosi), 32'd0);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done_err", 32'({done, err}), 32'd0);
        checkOutput("rst_rx_word", 32'(rx_word), 32'd0);
        checkOutput("rst_word_idx", 32'(word_idx), 32'd0);
        rst = 1'b0;
        monClear = 1'b0;
        tick();

        // Opcode 0x0000: single window, all-zero mosi
        $display("[TB] opcode 0x0000");
        clearMonitor();
        applyStimulus(16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, lat, readyHigh);
        checkOutput("op0_latency", 32'(lat), 32'd70);
        checkOutput("op0_ready_low", 32'(readyHigh), 32'd0);
        checkOutput("op0_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("op0_windows", 32'(monWin), 32'd1);
        checkOutput("op0_rises", 32'(seenRises[0]), 32'd16);
        checkOutput("op0_word", 32'(seenWords[0]), 32'h0000);
        checkOutput("op0_rx_word", 32'(rx_word), 32'h1234);
        checkOutput("op0_idle_ready", 32'(cmd_ready), 32'd1);
        checkOutput("op0_idle_busy", 32'(busy), 32'd0);

        // Opcode 0x0003: three windows
        $display("[TB] opcode 0x0003");
        clearMonitor();
        applyStimulus(16'h0003, 16'h3FC0, 16'h4000, 1'b0, lat, readyHigh);
        checkOutput("op3_latency", 32'(lat), 32'd208);
        checkOutput("op3_ready_low", 32'(readyHigh), 32'd0);
        tick();
        checkOutput("op3_windows", 32'(monWin), 32'd3);
        checkOutput("op3_word0", 32'(seenWords[0]), 32'h0003);
        checkOutput("op3_word1", 32'(seenWords[1]), 32'h3FC0);
        checkOutput("op3_word2", 32'(seenWords[2]), 32'h4000);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("op3_rises%0d", i), 32'(seenRises[i]), 32'd16);
            checkOutput($sformatf("op3_idx%0d", i), 32'(seenIdx[i]), 32'(i));
        end
        checkOutput("op3_gap1", 32'(seenGap[1]), 32'd4);
        checkOutput("op3_gap2", 32'(seenGap[2]), 32'd4);
        checkOutput("op3_stray_sck", 32'(straySck), 32'd0);
        checkOutput("op3_rx_word", 32'(rx_word), 32'hBEEF);

        // Opcode 0x0007: two windows, slave returns 0x3F40 on the second
        $display("[TB] opcode 0x0007");
        slaveWords[0] = 16'hA5A5;
        slaveWords[1] = 16'h3F40;
        clearMonitor();
        applyStimulus(16'h0007, 16'h3F00, 16'h1111, 1'b0, lat, readyHigh);
        checkOutput("op7_latency", 32'(lat), 32'd139);
        checkOutput("op7_rx_at_done", 32'(rx_word), 32'h3F40);
        tick();
        checkOutput("op7_windows", 32'(monWin), 32'd2);
        checkOutput("op7_word0", 32'(seenWords[0]), 32'h0007);
        checkOutput("op7_word1", 32'(seenWords[1]), 32'h3F00);

        // Illegal opcode 0x000B
        $display("[TB] opcode 0x000B");
        clearMonitor();
        tick();
        cmd_valid  = 1'b1;
        cmd_opcode = 16'h000B;
        tick();
        cmd_valid = 1'b0;
        checkOutput("opB_err_pulse", 32'(err), 32'd1);
        checkOutput("opB_ready", 32'(cmd_ready), 32'd1);
        checkOutput("opB_busy", 32'(busy), 32'd0);
        checkOutput("opB_cs", 32'(cs), 32'd1);
        tick();
        checkOutput("opB_err_clear", 32'(err), 32'd0);
        repeat (10) tick();
        checkOutput("opB_windows", 32'(monWin), 32'd0);
        checkOutput("opB_stray_sck", 32'(straySck), 32'd0);
        checkOutput("opB_rx_word", 32'(rx_word), 32'h3F40);

        // Reset during bit 7 of the second word of 0x0005
        $display("[TB] reset mid-word");
        clearMonitor();
        tick();
        cmd_valid  = 1'b1;
        cmd_opcode = 16'h0005;
        cmd_op_a   = 16'h4040;
        cmd_op_b   = 16'h3F80;
        tick();
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (monWin == 2 && monRise == 7 && !sck) found = 1'b1;
            else tick();
        end
        checkOutput("rstmid_reached", 32'(found), 32'd1);
        checkOutput("rstmid_word_idx_before", 32'(word_idx), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_cs", 32'(cs), 32'd1);
        checkOutput("rstmid_sck", 32'(sck), 32'd0);
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        checkOutput("rstmid_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rstmid_word_idx", 32'(word_idx), 32'd0);
        checkOutput("rstmid_rx_word", 32'(rx_word), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        slaveWords[0] = 16'h0F0F;
        clearMonitor();
        applyStimulus(16'h0002, 16'h0000, 16'h0000, 1'b0, lat, readyHigh);
        checkOutput("after_rst_latency", 32'(lat), 32'd70);
        tick();
        checkOutput("after_rst_windows", 32'(monWin), 32'd1);
        checkOutput("after_rst_word", 32'(seenWords[0]), 32'h0002);
        checkOutput("after_rst_rx_word", 32'(rx_word), 32'h0F0F);

        // cmd_valid held high with changing inputs while busy
        $display("[TB] valid held while busy");
        slaveWords[0] = 16'h0000;
        slaveWords[1] = 16'h0000;
        slaveWords[2] = 16'h0000;
        clearMonitor();
        applyStimulus(16'h0001, 16'h1357, 16'h2468, 1'b1, lat, readyHigh);
        checkOutput("hold_latency", 32'(lat), 32'd139);
        checkOutput("hold_ready_low", 32'(readyHigh), 32'd0);
        tick();
        checkOutput("hold_idle_ready", 32'(cmd_ready), 32'd1);
        checkOutput("hold_idle_busy", 32'(busy), 32'd0);
        checkOutput("hold_windows_first", 32'(monWin), 32'd2);
        checkOutput("hold_word0", 32'(seenWords[0]), 32'h0001);
        checkOutput("hold_word1", 32'(seenWords[1]), 32'h1357);
        tick();
        checkOutput("hold_second_busy", 32'(busy), 32'd1);
        checkOutput("hold_second_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        found = 1'b0;
        lat = 0;
        while (!found && lat < 2000) begin
            tick();
            lat = lat + 1;
            if (done) found = 1'b1;
        end
        checkOutput("hold_second_done", 32'(found), 32'd1);
        checkOutput("hold_second_latency", 32'(lat), 32'd69);
        tick();
        checkOutput("hold_windows_total", 32'(monWin), 32'd3);
        checkOutput("hold_second_word", 32'(seenWords[2]), 32'h0002);
        checkOutput("hold_stray_sck", 32'(straySck), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
